// File: rtl/riscv_lsu_pkg.sv
// Shared types and lane helpers for the load/store unit.
// Sizes follow the funct3[1:0] encoding; size 3 is always treated as illegal.
package riscv_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        LWAIT  = 2'd2,
        RESP   = 2'd3
    } lsu_state_e;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = off[0];
            SZ_W:    misaligned = (off != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] wstrb_gen(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    wstrb_gen = 4'b0001 << off;
            SZ_H:    wstrb_gen = off[1] ? 4'b1100 : 4'b0011;
            SZ_W:    wstrb_gen = 4'b1111;
            default: wstrb_gen = 4'b0000;
        endcase
    endfunction

    // Replicating across lanes lets the strobes alone select the target bytes.
    function automatic logic [31:0] wdata_rep(input logic [1:0] size, input logic [31:0] d);
        case (size)
            SZ_B:    wdata_rep = {4{d[7:0]}};
            SZ_H:    wdata_rep = {2{d[15:0]}};
            default: wdata_rep = d;
        endcase
    endfunction

endpackage

// File: rtl/riscv_lsu_extract.sv
// Selects the addressed lane of a memory word and sign/zero-extends it.
// Purely combinational so the fetch side can share it.
module riscv_lsu_extract
    import riscv_lsu_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] rdata
);

    logic [31:0] lane;

    always_comb begin
        lane = mem_rdata >> {off, 3'b000};
        case (size)
            SZ_B:    rdata = {{24{~is_unsigned & lane[7]}}, lane[7:0]};
            SZ_H:    rdata = {{16{~is_unsigned & lane[15]}}, lane[15:0]};
            default: rdata = lane;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Data-side load/store initiator: one request at a time onto a single-port
// word bus with one-cycle read latency; misaligned requests never reach memory.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e  state_reg;
    logic        we_reg;
    logic [1:0]  size_reg;
    logic [1:0]  off_reg;
    logic        uns_reg;
    logic [31:0] ext_rdata;

    riscv_lsu_extract u_extract (
        .mem_rdata   (mem_rdata),
        .off         (off_reg),
        .size        (size_reg),
        .is_unsigned (uns_reg),
        .rdata       (ext_rdata)
    );

    // req_ready is only ever high in IDLE/RESP, so a handshake implies one of those.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
            mem_addr  <= '0;
            mem_read  <= 1'b0;
            mem_wstrb <= 4'b0000;
            mem_wdata <= 32'd0;
            we_reg    <= 1'b0;
            size_reg  <= 2'd0;
            off_reg   <= 2'd0;
            uns_reg   <= 1'b0;
        end else if (req_valid && req_ready) begin
            we_reg    <= req_we;
            size_reg  <= req_size;
            off_reg   <= req_addr[1:0];
            uns_reg   <= req_unsigned;
            rsp_rdata <= 32'd0;
            if (misaligned(req_size, req_addr[1:0])) begin
                state_reg <= RESP;
                req_ready <= 1'b1;
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                mem_read  <= 1'b0;
                mem_wstrb <= 4'b0000;
            end else begin
                state_reg <= ACCESS;
                req_ready <= 1'b0;
                rsp_valid <= 1'b0;
                rsp_err   <= 1'b0;
                mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                mem_wdata <= wdata_rep(req_size, req_wdata);
                mem_read  <= ~req_we;
                mem_wstrb <= req_we ? wstrb_gen(req_size, req_addr[1:0]) : 4'b0000;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    req_ready <= 1'b1;
                end
                ACCESS: begin
                    mem_read  <= 1'b0;
                    mem_wstrb <= 4'b0000;
                    if (we_reg) begin
                        state_reg <= RESP;
                        rsp_valid <= 1'b1;
                        req_ready <= 1'b1;
                    end else begin
                        state_reg <= LWAIT;
                    end
                end
                LWAIT: begin
                    rsp_rdata <= ext_rdata;
                    state_reg <= RESP;
                    rsp_valid <= 1'b1;
                    req_ready <= 1'b1;
                end
                RESP: begin
                    state_reg <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Scoreboard bench for riscv_lsu: byte-array reference model, word bus memory,
// directed scenarios followed by randomized traffic.
module tb_riscv_lsu;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;

    riscv_lsu #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_rdata    (rsp_rdata),
        .mem_addr     (mem_addr),
        .mem_read     (mem_read),
        .mem_wstrb    (mem_wstrb),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors = 0;
    int cyc = 0;
    int rsp_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Word-wide bus memory; data returned one cycle after mem_read, noise otherwise.
    logic [31:0] bus_mem [0:63];
    always @(posedge clk) begin
        if (mem_read) mem_rdata <= bus_mem[mem_addr[7:2]];
        else          mem_rdata <= $urandom;
        for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) bus_mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end

    logic [7:0] ref_mem [0:255];

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic        rd;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] addr;
        int          cyc;
    } strb_t;

    rsp_t  rsp_q[$];
    strb_t strb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid) begin
            rsp_count++;
            if (rsp_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                rsp_t e;
                e = rsp_q.pop_front();
                check("rsp_err", 32'(rsp_err), 32'(e.err));
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_cycle", cyc, e.cyc);
            end
        end
        if (mem_read || mem_wstrb != 4'b0000) begin
            check("ready_in_access", 32'(req_ready), 32'd0);
            if (strb_q.size() == 0) begin
                check("strobe_unexpected", {27'd0, mem_read, mem_wstrb}, 32'd0);
            end else begin
                strb_t s;
                s = strb_q.pop_front();
                check("mem_read", 32'(mem_read), 32'(s.rd));
                check("mem_wstrb", 32'(mem_wstrb), 32'(s.wstrb));
                check("mem_addr", mem_addr, s.addr);
                check("strobe_cycle", cyc, s.cyc);
                if (!s.rd) check("mem_wdata", mem_wdata, s.wdata);
            end
        end
    end

    // Presents one request, waits for the handshake and records the expected outcome.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [7:0] addr, input logic [31:0] d, output int acc);
        int n = 0;
        int nb;
        logic mis;
        logic [31:0] v;
        rsp_t r;
        strb_t s;
        req_valid = 1'b1;
        req_we = we;
        req_size = size;
        req_unsigned = uns;
        req_addr = {24'd0, addr};
        req_wdata = d;
        acc = -1;
        @(negedge clk);
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        mis = (size == 2'd3) || (addr % nb != 0);
        if (mis) begin
            r = '{1'b1, 32'd0, acc};
            rsp_q.push_back(r);
        end else if (we) begin
            for (int i = 0; i < nb; i++) ref_mem[int'(addr) + i] = d[8*i +: 8];
            s.rd = 1'b0;
            s.wstrb = 4'(((1 << nb) - 1) << addr[1:0]);
            s.wdata = (nb == 1) ? {4{d[7:0]}} : (nb == 2) ? {2{d[15:0]}} : d;
            s.addr = {24'd0, addr[7:2], 2'b00};
            s.cyc = acc;
            strb_q.push_back(s);
            r = '{1'b0, 32'd0, acc + 1};
            rsp_q.push_back(r);
        end else begin
            v = 32'd0;
            for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[int'(addr) + i]) << (8 * i));
            if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
            s = '{1'b1, 4'b0000, 32'd0, {24'd0, addr[7:2], 2'b00}, acc};
            strb_q.push_back(s);
            r = '{1'b0, v, acc + 2};
            rsp_q.push_back(r);
        end
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_all_zero(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_read"}, 32'(mem_read), 32'd0);
        check({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout at cyc %0d", cyc);
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int a0, a1, a2, cnt0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        for (int w = 0; w < 64; w++)
            bus_mem[w] <= {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        expect_all_zero("reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", 32'(req_ready), 32'd1);

        issue(1'b1, 2'd2, 1'b0, 8'h10, 32'hDEAD_BEEF, a0); idle(2);
        issue(1'b0, 2'd2, 1'b0, 8'h10, 32'd0, a0);         idle(4);

        issue(1'b1, 2'd2, 1'b0, 8'h10, 32'h1122_3344, a0); idle(1);
        issue(1'b1, 2'd0, 1'b0, 8'h13, 32'h0000_0080, a0); idle(1);
        issue(1'b0, 2'd0, 1'b0, 8'h13, 32'd0, a0);         idle(1);
        issue(1'b0, 2'd0, 1'b1, 8'h13, 32'd0, a0);         idle(1);
        issue(1'b0, 2'd2, 1'b0, 8'h10, 32'd0, a0);         idle(4);

        issue(1'b1, 2'd1, 1'b0, 8'h22, 32'h0000_8001, a0); idle(1);
        issue(1'b0, 2'd1, 1'b0, 8'h22, 32'd0, a0);         idle(1);
        issue(1'b0, 2'd1, 1'b1, 8'h22, 32'd0, a0);         idle(4);

        issue(1'b0, 2'd2, 1'b0, 8'h11, 32'd0, a0);         idle(1);
        issue(1'b0, 2'd1, 1'b0, 8'h23, 32'd0, a0);         idle(1);
        issue(1'b1, 2'd3, 1'b0, 8'h00, 32'h1234_5678, a0); idle(3);

        // Back-to-back: each next request is taken in the previous RESP cycle.
        cnt0 = rsp_count;
        issue(1'b1, 2'd2, 1'b0, 8'h30, 32'hCAFE_F00D, a0);
        issue(1'b0, 2'd2, 1'b0, 8'h30, 32'd0, a1);
        issue(1'b1, 2'd2, 1'b0, 8'h34, 32'h0BAD_CAFE, a2);
        idle(6);
        check("b2b_sw_lw_gap", a1 - a0, 32'd2);
        check("b2b_lw_sw_gap", a2 - a1, 32'd3);
        check("b2b_rsp_count", rsp_count - cnt0, 32'd3);

        // Reset asserted so it is sampled at the end of the load's LWAIT cycle.
        issue(1'b0, 2'd2, 1'b0, 8'h10, 32'd0, a0);
        req_valid = 1'b0;
        void'(rsp_q.pop_back());
        @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        expect_all_zero("midreset");
        idle(2);
        issue(1'b0, 2'd2, 1'b0, 8'h10, 32'd0, a0);         idle(4);

        for (int k = 0; k < 200; k++) begin
            logic [1:0] sz;
            int gap;
            sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)), $urandom, a0);
            gap = $urandom_range(0, 2);
            if (gap > 0) idle(gap);
        end
        idle(10);

        check("rsp_queue_drained", rsp_q.size(), 32'd0);
        check("strobe_queue_drained", strb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
